// File: rtl/apple_place.sv
// Picks a pseudo-random empty cell of a snapshot of the game field:
// an LFSR value reduced modulo the empty-cell count selects which empty cell a linear scan stops on.
module apple_place #(
    parameter int SIZE_X     = 10,
    parameter int SIZE_Y     = 10,
    parameter int FIELD_SIZE = SIZE_X * SIZE_Y * 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FIELD_SIZE-1:0] field,
    input  logic [15:0]           empty_cells,
    output logic                  busy,
    output logic                  done,
    output logic                  no_space,
    output logic                  apple_valid,
    output logic [7:0]            apple_x,
    output logic [7:0]            apple_y
);

    localparam int          N        = SIZE_X * SIZE_Y;
    localparam logic [15:0] LAST_IDX = 16'(N - 1);
    localparam logic [7:0]  LAST_X   = 8'(SIZE_X - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOD  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]           lfsr;
    logic [FIELD_SIZE-1:0] snap;
    logic [15:0]           divisor;
    logic [15:0]           dividend;
    logic [16:0]           rem;
    logic [3:0]            bit_cnt;
    logic [15:0]           idx;
    logic [15:0]           k;
    logic [7:0]            x_cnt;
    logic [7:0]            y_cnt;

    logic [16:0] rem_shift;
    logic        rem_ge;
    logic        cell_empty;
    logic        scan_match;
    logic        scan_last;

    // Free-running source of randomness; only reset stops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Restoring division step: shift in the next dividend bit MSB first.
    always_comb begin
        rem_shift = {rem[15:0], dividend[15]};
        rem_ge    = (rem_shift >= {1'b0, divisor});
    end

    // The snapshot shifts right by one cell per SCAN cycle, so bits [1:0] are always cell idx.
    always_comb begin
        cell_empty = (snap[1:0] == 2'b00);
        scan_match = cell_empty && ({1'b0, k} == rem);
        scan_last  = (idx == LAST_IDX);
    end

    // start/busy handshake: start is a one-cycle strobe, accepted only in IDLE (busy low);
    // a strobe while busy is dropped, never queued. done pulses once per accepted request.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (empty_cells == 16'd0) ? DONE : MOD;
                end
            end
            MOD: begin
                if (bit_cnt == 4'd15) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (scan_match || scan_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy and done are registered copies of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap        <= '0;
            divisor     <= '0;
            dividend    <= '0;
            rem         <= '0;
            bit_cnt     <= '0;
            idx         <= '0;
            k           <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            no_space    <= 1'b0;
            apple_valid <= 1'b0;
            apple_x     <= '0;
            apple_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= field;
                        divisor  <= empty_cells;
                        dividend <= lfsr;
                        rem      <= '0;
                        bit_cnt  <= '0;
                        idx      <= '0;
                        k        <= '0;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        if (empty_cells == 16'd0) begin
                            no_space    <= 1'b1;
                            apple_valid <= 1'b0;
                        end
                    end
                end
                MOD: begin
                    rem      <= rem_ge ? (rem_shift - {1'b0, divisor}) : rem_shift;
                    dividend <= {dividend[14:0], 1'b0};
                    bit_cnt  <= bit_cnt + 4'd1;
                end
                SCAN: begin
                    if (scan_match) begin
                        apple_x     <= x_cnt;
                        apple_y     <= y_cnt;
                        apple_valid <= 1'b1;
                        no_space    <= 1'b0;
                    end else if (scan_last) begin
                        // A count inconsistent with the field ends here at worst.
                        apple_valid <= 1'b0;
                        no_space    <= 1'b1;
                    end else begin
                        snap <= snap >> 2;
                        idx  <= idx + 16'd1;
                        k    <= k + {15'd0, cell_empty};
                        if (x_cnt == LAST_X) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + 8'd1;
                        end else begin
                            x_cnt <= x_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple_place.sv
// Directed bench for apple_place on the default 10x10 field: a vector table of
// reset-then-start requests (LFSR known to be 0xACE1) plus multi-cycle corner sequences.
module tb_apple_place;

  localparam int SX = 10;
  localparam int SY = 10;
  localparam int NC = SX * SY;
  localparam int FS = NC * 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [FS-1:0] field;
  logic [15:0]   empty_cells;
  logic          busy;
  logic          done;
  logic          no_space;
  logic          apple_valid;
  logic [7:0]    apple_x;
  logic [7:0]    apple_y;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  apple_place #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .field(field),
    .empty_cells(empty_cells),
    .busy(busy),
    .done(done),
    .no_space(no_space),
    .apple_valid(apple_valid),
    .apple_x(apple_x),
    .apple_y(apple_y)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  typedef struct {
    int          stride;  // 0: no empty cells; else empty at offs, offs+stride, ...
    int          offs;
    logic [1:0]  fill;
    logic [15:0] ecells;
    int          lat;     // cycles from acceptance to the done pulse
    logic        ns;
    logic        valid;
    logic [7:0]  x;
    logic [7:0]  y;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [FS-1:0] make_field(input int stride, input int offs, input logic [1:0] fill);
    logic [FS-1:0] f;
    f = '0;
    for (int i = 0; i < NC; i++) begin
      if (stride != 0 && i >= offs && ((i - offs) % stride) == 0) f[2*i +: 2] = 2'b00;
      else f[2*i +: 2] = fill;
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // driver tasks; all are entered and left 1 time unit after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [FS-1:0] f, input logic [15:0] e);
    field = f;
    empty_cells = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < limit) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic check_outputs(input string tag, input logic b, input logic d, input logic ns,
                               input logic v, input logic [7:0] x, input logic [7:0] y);
    check({tag, "_busy"}, 32'(busy), 32'(b));
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_no_space"}, 32'(no_space), 32'(ns));
    check({tag, "_valid"}, 32'(apple_valid), 32'(v));
    check({tag, "_x"}, 32'(apple_x), 32'(x));
    check({tag, "_y"}, 32'(apple_y), 32'(y));
  endtask

  initial begin
    logic [FS-1:0] all_empty;
    int lat;
    int n;
    int base;

    // After reset the LFSR reads 0xACE1 = 44257 in the first cycle, so targets are 44257 mod ecells.
    //                stride offs fill   ecells lat   ns    valid x     y
    vecs[0] = '{1,    0,   2'b01, 16'd100, 75,  1'b0, 1'b1, 8'd7, 8'd5};  // 57 -> cell 57
    vecs[1] = '{1000, 99,  2'b01, 16'd1,   117, 1'b0, 1'b1, 8'd9, 8'd9};  // only cell 99
    vecs[2] = '{0,    0,   2'b01, 16'd5,   117, 1'b1, 1'b0, 8'd0, 8'd0};  // full, wrong count
    vecs[3] = '{1,    0,   2'b01, 16'd0,   1,   1'b1, 1'b0, 8'd0, 8'd0};  // zero count
    vecs[4] = '{2,    0,   2'b01, 16'd50,  32,  1'b0, 1'b1, 8'd4, 8'd1};  // 7 -> cell 14
    vecs[5] = '{3,    1,   2'b01, 16'd33,  31,  1'b0, 1'b1, 8'd3, 8'd1};  // 4 -> cell 13
    vecs[6] = '{7,    2,   2'b11, 16'd14,  41,  1'b0, 1'b1, 8'd3, 8'd2};  // 3 -> cell 23
    vecs[7] = '{10,   0,   2'b10, 16'd200, 117, 1'b1, 1'b0, 8'd0, 8'd0};  // 57 > 10 empties
    vecs[8] = '{1,    0,   2'b01, 16'd1,   18,  1'b0, 1'b1, 8'd0, 8'd0};  // first cell

    all_empty = make_field(1, 0, 2'b01);
    rst = 1'b1;
    start = 1'b0;
    field = '0;
    empty_cells = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      do_reset();
      do_start(make_field(vecs[i].stride, vecs[i].offs, vecs[i].fill), vecs[i].ecells);
      check($sformatf("v%0d_busy_c1", i), 32'(busy), 32'd1);
      wait_done(200, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check_outputs($sformatf("v%0d", i), 1'b1, 1'b1, vecs[i].ns, vecs[i].valid, vecs[i].x, vecs[i].y);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_fall", i), 32'(done), 32'd0);
      check($sformatf("v%0d_busy_fall", i), 32'(busy), 32'd0);
    end

    // start while busy and field rewritten mid-SCAN: only the snapshot (cell 23) counts
    do_reset();
    base = done_cnt;
    do_start(make_field(1000, 23, 2'b01), 16'd1);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      if (n == 5 || n == 30) begin
        start = 1'b1;
        field = all_empty;
        empty_cells = 16'd100;
      end else begin
        start = 1'b0;
      end
      if (n == 20) field = all_empty;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("busy_ign_lat", 32'(n), 32'd41);
    check_outputs("busy_ign", 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd2);
    @(posedge clk); #1;
    check("busy_ign_one_done", 32'(done_cnt - base), 32'd1);

    // accepted again in the cycle right after DONE; zero count keeps old coordinates
    do_start(all_empty, 16'd0);
    check_outputs("empty_after_done", 1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'd2);
    repeat (5) @(posedge clk);
    #1;
    check_outputs("no_space_hold", 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd2);

    // a match clears no_space (count 1 makes the LFSR value irrelevant)
    do_start(make_field(1000, 55, 2'b11), 16'd1);
    wait_done(200, lat);
    check("match_clear_lat", 32'(lat), 32'd73);
    check_outputs("match_clear", 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 8'd5);

    // reset mid-SCAN after a placed apple
    @(posedge clk); #1;
    base = done_cnt;
    do_start(make_field(1000, 99, 2'b01), 16'd1);
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs("rst_mid_scan", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check("rst_no_done", 32'(done_cnt - base), 32'd0);
    do_start(all_empty, 16'd100);
    wait_done(200, lat);
    check("after_rst_lat", 32'(lat), 32'd75);
    check_outputs("after_rst", 1'b1, 1'b1, 1'b0, 1'b1, 8'd7, 8'd5);
    @(posedge clk); #1;
    check("after_rst_one_done", 32'(done_cnt - base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
